// File: rtl/jt51_acc_mix.sv
// Stereo accumulator for the time-multiplexed FM operator pipeline.
// Per-channel carrier sums are built in a CH-entry delay line over the four
// operator groups (M1,M2,C1,C2), then folded into left/right frame sums that
// are shifted by the volume code and saturated once per 4*CH-slot frame.
module jt51_acc_mix #(
    parameter int CH   = 8,
    parameter int OPW  = 14,
    parameter int NW   = 12,
    parameter int ACCW = 16,
    parameter int OUTW = 16,
    parameter int VOLW = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cen,
    input  logic                   sync,
    input  logic [2:0]             con,
    input  logic [1:0]             rl,
    input  logic signed [OPW-1:0]  op_out,
    input  logic                   ne,
    input  logic signed [NW-1:0]   noise,
    input  logic [VOLW-1:0]        vol_l,
    input  logic [VOLW-1:0]        vol_r,
    input  logic                   clip_clr,
    output logic signed [OUTW-1:0] left,
    output logic signed [OUTW-1:0] right,
    output logic                   sample_valid,
    output logic                   clip_l,
    output logic                   clip_r,
    output logic                   locked
);

    localparam int NS = 4 * CH;
    localparam int SW = $clog2(NS);
    localparam int CW = $clog2(CH);
    localparam int FW = ACCW + CW + 1;

    logic [SW-1:0]          slot;
    logic [SW-1:0]          cur;
    logic [1:0]             grp;
    logic [CW-1:0]          ch;
    logic                   last;
    logic                   en;
    logic signed [OPW-1:0]  noise_x;
    logic signed [OPW-1:0]  opnd;
    logic signed [OPW-1:0]  addv;
    logic signed [ACCW-1:0] base;
    logic signed [ACCW:0]   wide;
    logic signed [ACCW-1:0] entry;
    logic signed [FW-1:0]   entry_x;
    logic signed [FW-1:0]   fl, fr, fl_n, fr_n;
    logic signed [FW-1:0]   shl_l, shl_r;
    logic [OUTW:0]          sat_l, sat_r;
    logic signed [ACCW-1:0] dl [CH];

    // Clamp an ACCW+1 bit sum back into ACCW bits.
    function automatic logic signed [ACCW-1:0] sat_acc(input logic signed [ACCW:0] x);
        if (x[ACCW] != x[ACCW-1])
            return x[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
        return x[ACCW-1:0];
    endfunction

    // Clamp a frame value into OUTW bits; MSB of the result flags saturation.
    function automatic logic [OUTW:0] sat_out(input logic signed [FW-1:0] x);
        logic [FW-OUTW:0] top;
        top = x[FW-1:OUTW-1];
        if (&top || ~|top)
            return {1'b0, x[OUTW-1:0]};
        return x[FW-1] ? {2'b11, {(OUTW-1){1'b0}}} : {2'b10, {(OUTW-1){1'b1}}};
    endfunction

    // Slot decode, operand select, channel sum update and frame output values.
    always_comb begin
        cur     = sync ? '0 : slot;
        grp     = cur[SW-1 -: 2];
        ch      = cur[CW-1:0];
        last    = (cur == SW'(NS - 1));
        noise_x = OPW'(noise);
        opnd    = (ne && last) ? noise_x : op_out;
        case (grp)
            2'd0:    en = (con == 3'd7);
            2'd1:    en = (con >= 3'd5);
            2'd2:    en = (con >= 3'd4);
            default: en = 1'b1;
        endcase
        addv    = en ? opnd : '0;
        base    = (grp == 2'd0) ? '0 : dl[ch];
        wide    = (ACCW+1)'(base) + (ACCW+1)'(addv);
        entry   = sat_acc(wide);
        entry_x = FW'(entry);
        // A sync always starts a fresh frame, so the old frame sums are dropped.
        fl_n = sync ? '0 : fl;
        fr_n = sync ? '0 : fr;
        if (grp == 2'd3 && rl[0]) fl_n = fl_n + entry_x;
        if (grp == 2'd3 && rl[1]) fr_n = fr_n + entry_x;
        shl_l = fl_n >>> vol_l;
        shl_r = fr_n >>> vol_r;
        sat_l = sat_out(shl_l);
        sat_r = sat_out(shl_r);
    end

    // Slot counter, lock flag, delay line and frame sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot   <= '0;
            locked <= 1'b0;
            fl     <= '0;
            fr     <= '0;
            for (int i = 0; i < CH; i++) dl[i] <= '0;
        end else if (cen) begin
            slot <= cur + SW'(1);
            if (sync) begin
                locked <= 1'b1;
                for (int i = 0; i < CH; i++) dl[i] <= '0;
            end
            dl[ch] <= entry;
            if (last) begin
                fl <= '0;
                fr <= '0;
            end else begin
                fl <= fl_n;
                fr <= fr_n;
            end
        end
    end

    // Output sample, valid pulse and sticky clip flags (clear ignores cen; set wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left         <= '0;
            right        <= '0;
            sample_valid <= 1'b0;
            clip_l       <= 1'b0;
            clip_r       <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (clip_clr) begin
                clip_l <= 1'b0;
                clip_r <= 1'b0;
            end
            if (cen && last && locked) begin
                left         <= sat_l[OUTW-1:0];
                right        <= sat_r[OUTW-1:0];
                sample_valid <= 1'b1;
                if (sat_l[OUTW]) clip_l <= 1'b1;
                if (sat_r[OUTW]) clip_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jt51_acc_mix.sv
// Bench for jt51_acc_mix: frame-level reference model plus directed scenarios
// and a randomized run with cen gaps, stray syncs and clip clears.
module tb_jt51_acc_mix;

    localparam int CH = 8, OPW = 14, NW = 12, ACCW = 16, OUTW = 16, VOLW = 4;
    localparam int NS = 4 * CH;

    logic clk = 1'b0, rst_n = 1'b1, cen = 1'b0, sync = 1'b0, ne = 1'b0, clip_clr = 1'b0;
    logic [2:0] con = '0;
    logic [1:0] rl = '0;
    logic signed [OPW-1:0] op_out = '0;
    logic signed [NW-1:0]  noise = '0;
    logic [VOLW-1:0] vol_l = '0, vol_r = '0;
    logic signed [OUTW-1:0] left, right;
    logic sample_valid, clip_l, clip_r, locked;

    jt51_acc_mix #(.CH(CH), .OPW(OPW), .NW(NW), .ACCW(ACCW), .OUTW(OUTW), .VOLW(VOLW)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .sync(sync), .con(con), .rl(rl),
        .op_out(op_out), .ne(ne), .noise(noise), .vol_l(vol_l), .vol_r(vol_r),
        .clip_clr(clip_clr), .left(left), .right(right), .sample_valid(sample_valid),
        .clip_l(clip_l), .clip_r(clip_r), .locked(locked)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0, vcount = 0;

    // Reference model state: whole-frame record, evaluated at the frame's last slot.
    int     m_slot = 0;
    bit     m_locked = 0, m_valid = 0, m_clip_l = 0, m_clip_r = 0;
    longint m_left = 0, m_right = 0;
    int     f_op [NS];
    int     f_con[NS];
    int     f_rl [NS];

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Number of groups that contribute, counted back from C2.
    function automatic int n_groups(input int c);
        if (c == 7) return 4;
        if (c >= 5) return 3;
        if (c == 4) return 2;
        return 1;
    endfunction

    function automatic longint clamp(input longint v, input int w);
        longint lo, hi;
        lo = -(longint'(1) <<< (w - 1));
        hi = (longint'(1) <<< (w - 1)) - 1;
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    always @(negedge rst_n) begin
        m_slot = 0; m_locked = 0; m_valid = 0; m_clip_l = 0; m_clip_r = 0;
        m_left = 0; m_right = 0;
    end

    // Model step on every active edge outside reset.
    always @(posedge clk) if (rst_n) begin : mdl
        longint fl, fr, acc, sl, sr;
        bit set_l, set_r;
        int s;
        set_l = 0; set_r = 0;
        m_valid = 0;
        if (cen) begin
            if (sync) begin m_slot = 0; m_locked = 1; end
            f_op[m_slot]  = (ne && m_slot == NS - 1) ? int'(noise) : int'(op_out);
            f_con[m_slot] = int'(con);
            f_rl[m_slot]  = int'(rl);
            if (m_slot == NS - 1) begin
                fl = 0; fr = 0;
                for (int c = 0; c < CH; c++) begin
                    acc = 0;
                    for (int g = 0; g < 4; g++) begin
                        s = g * CH + c;
                        if (g >= 4 - n_groups(f_con[s])) acc = clamp(acc + f_op[s], ACCW);
                    end
                    if (f_rl[3*CH+c] & 1) fl += acc;
                    if (f_rl[3*CH+c] & 2) fr += acc;
                end
                if (m_locked) begin
                    sl = fl >>> vol_l;
                    sr = fr >>> vol_r;
                    m_left  = clamp(sl, OUTW);
                    m_right = clamp(sr, OUTW);
                    set_l = (m_left != sl);
                    set_r = (m_right != sr);
                    m_valid = 1;
                end
            end
            m_slot = (m_slot + 1) % NS;
        end
        if (set_l) m_clip_l = 1; else if (clip_clr) m_clip_l = 0;
        if (set_r) m_clip_r = 1; else if (clip_clr) m_clip_r = 0;
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        check("left",   left,         m_left);
        check("right",  right,        m_right);
        check("valid",  sample_valid, m_valid);
        check("clip_l", clip_l,       m_clip_l);
        check("clip_r", clip_r,       m_clip_r);
        check("locked", locked,       m_locked);
        if (sample_valid) vcount++;
    end

    task automatic step(input bit c, input bit sy, input int cn, input int r, input int op,
                        input bit n, input int nz, input bit cc);
        @(negedge clk); #1;
        cen = c; sync = sy; con = 3'(cn); rl = 2'(r); op_out = OPW'(op);
        ne = n; noise = NW'(nz); clip_clr = cc;
    endtask

    // One frame: opm on M1/M2/C1 slots, opc on C2 slots; returns just after output update.
    task automatic frame(input bit sy, input int opm, input int opc, input int cn, input int r,
                         input bit n, input int nz);
        for (int s = 0; s < NS; s++)
            step(1'b1, sy && s == 0, cn, r, (s >= 3 * CH) ? opc : opm, n, nz, 1'b0);
        step(1'b0, 1'b0, cn, r, 0, 1'b0, 0, 1'b0);
    endtask

    initial begin : stim
        int v0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Full sum of all groups on both sides.
        frame(1'b1, 100, 100, 7, 3, 1'b0, 0);
        check("s1_model", m_left, 3200);
        check("s1_left", left, 3200);
        check("s1_right", right, 3200);
        check("s1_valid", sample_valid, 1);
        v0 = vcount;
        frame(1'b1, 100, 100, 7, 3, 1'b0, 0);
        check("s1_pulses", vcount - v0, 1);

        // Only C2 counts for con 0, left side only.
        frame(1'b1, 1000, 10, 0, 1, 1'b0, 0);
        check("s2_model", m_left, 80);
        check("s2_left", left, 80);
        check("s2_right", right, 0);

        // Saturation and sticky clip flags, then clear with cen low.
        frame(1'b1, 8191, 8191, 7, 3, 1'b0, 0);
        check("s3_left", left, 32767);
        check("s3_right", right, 32767);
        check("s3_clip_l", clip_l, 1);
        check("s3_clip_r", clip_r, 1);
        step(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0);
        check("s3_clr_l", clip_l, 0);
        check("s3_clr_r", clip_r, 0);

        // Mid-frame sync at slot 13 discards the partial frame.
        v0 = vcount;
        for (int s = 0; s < 13; s++) step(1'b1, s == 0, 7, 3, 5000, 1'b0, 0, 1'b0);
        frame(1'b1, 100, 100, 7, 3, 1'b0, 0);
        check("s4_pulses", vcount - v0, 1);
        check("s4_left", left, 3200);
        check("s4_right", right, 3200);

        // Noise replaces the final slot's operand.
        frame(1'b1, 0, 0, 7, 3, 1'b1, -5);
        check("s5_model", m_left, -5);
        check("s5_left", left, -5);
        check("s5_right", right, -5);

        // Reset mid-frame; an unsynced frame after it produces nothing.
        for (int s = 0; s < 10; s++) step(1'b1, s == 0, 7, 3, 100, 1'b0, 0, 1'b0);
        @(negedge clk); #1 rst_n = 1'b0;
        #1;
        check("s6_left", left, 0);
        check("s6_locked", locked, 0);
        check("s6_valid", sample_valid, 0);
        @(negedge clk); #1 rst_n = 1'b1;
        v0 = vcount;
        frame(1'b0, 100, 100, 7, 3, 1'b0, 0);
        check("s6_nolock_pulses", vcount - v0, 0);
        check("s6_nolock_left", left, 0);
        frame(1'b1, 100, 100, 7, 3, 1'b0, 0);
        check("s6_relock_pulses", vcount - v0, 1);
        check("s6_relock_left", left, 3200);

        // Randomized run against the model.
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk); #1;
            cen      = ($urandom_range(0, 4) != 0);
            sync     = cen && (m_slot == 0 || $urandom_range(0, 199) == 0);
            con      = 3'($urandom_range(0, 7));
            rl       = 2'($urandom_range(0, 3));
            op_out   = OPW'(int'($urandom_range(0, 16383)) - 8192);
            ne       = ($urandom_range(0, 1) != 0);
            noise    = NW'(int'($urandom_range(0, 4095)) - 2048);
            clip_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) begin
                vol_l = VOLW'($urandom_range(0, 15));
                vol_r = VOLW'($urandom_range(0, 15));
            end
        end
        step(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0);
        @(negedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
